euclid_gcd_stream: RTL and testbench



---
 rtl/euclid_gcd_stream_if.sv | 27 ++
 rtl/euclid_gcd_stream.sv | 101 ++++++++++
 tb/tb_euclid_gcd_stream.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/euclid_gcd_stream_if.sv
// Operand/result handshake bundle for euclid_gcd_stream; the master side is the
// producer/consumer and the slave side is the engine.
interface euclid_gcd_stream_if #(
  parameter int W = 16
);
  localparam int CW = W + 1;

  logic [W-1:0]  operand_A;
  logic [W-1:0]  operand_B;
  logic          input_available;
  logic          input_ready;
  logic [W-1:0]  result_data;
  logic          result_rdy;
  logic          result_taken;
  logic [CW-1:0] iter_count;
  logic [1:0]    state;

  modport master (
    output operand_A, operand_B, input_available, result_taken,
    input  input_ready, result_data, result_rdy, iter_count, state
  );

  modport slave (
    input  operand_A, operand_B, input_available, result_taken,
    output input_ready, result_data, result_rdy, iter_count, state
  );
endinterface

// File: rtl/euclid_gcd_stream.sv
// Handshaked subtract-and-swap Euclidean GCD engine, one step per clock.
// Define GCD_ITER_COUNT_EN to build the saturating CALC-cycle counter on iter_count.
module euclid_gcd_stream #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  euclid_gcd_stream_if.slave   bus
);
  localparam int CW = W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           accept;

  assign accept = (state_q == S_IDLE) && bus.input_available;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Encoding 2'd3 falls into default and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.input_available) state_d = S_CALC;
      S_CALC:  if (b_q == '0)           state_d = S_DONE;
      S_DONE:  if (bus.result_taken)    state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.input_ready = (state_q == S_IDLE);
    bus.result_rdy  = (state_q == S_DONE);
    bus.state       = state_q;
  end

  assign bus.result_data = res_q;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (accept) begin
      a_d = bus.operand_A;
      b_d = bus.operand_B;
    end else if (state_q == S_CALC) begin
      if (a_q < b_q) begin
        a_d = b_q;
        b_d = a_q;
      end else if (b_q != '0) begin
        a_d = a_q - b_q;
      end else begin
        res_d = a_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

`ifdef GCD_ITER_COUNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  // Held through DONE and IDLE; only a new acceptance clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)                                cnt_d = '0;
    else if (state_q == S_CALC && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.iter_count = cnt_q;
`else
  assign bus.iter_count = '0;
`endif

endmodule

// File: tb/tb_euclid_gcd_stream.sv
// Scoreboard bench for euclid_gcd_stream: W=16 directed pairs plus a W=4 worst case.
module tb_euclid_gcd_stream;
  logic clk;
  logic reset_n;

  euclid_gcd_stream_if #(.W(16)) bus ();
  euclid_gcd_stream_if #(.W(4))  bus4 ();

  euclid_gcd_stream #(.W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  euclid_gcd_stream #(.W(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  typedef struct {
    logic [15:0] res;
    int unsigned n;
    int unsigned hold;
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  exp_t        q4[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int unsigned exp_it(input int unsigned n);
`ifdef GCD_ITER_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Holds input_available until the engine accepts; called on a negedge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int unsigned n,
                      input int unsigned hold, input logic [15:0] r);
    bit ok = 0;
    bus.operand_A       = a;
    bus.operand_B       = b;
    bus.input_available = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (bus.input_ready) ok = 1;
      @(negedge clk);
    end
    bus.input_available = 1'b0;
    bus.operand_A       = 16'hFFFF;
    bus.operand_B       = 16'h0001;
    chk("accept_timeout", ok, 1);
    if (ok) q.push_back('{res: r, n: n, hold: hold, acc: cyc});
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (q.size() != 0 || q4.size() != 0 || bus.state != 2'd0); i++)
      @(negedge clk);
    chk("drain_pending", q.size() + q4.size(), 0);
  endtask

  // Main monitor and consumer: pops on each result_rdy rise, then applies backpressure.
  exp_t        cur;
  bit          prev_rdy = 0;
  bit          took     = 0;
  int unsigned hold_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rdy         = 0;
      took             = 0;
      hold_cnt         = 0;
      bus.result_taken = 1'b0;
    end else begin
      chk("ready_rdy_exclusive", bus.input_ready & bus.result_rdy, 0);
      if (bus.result_rdy && !prev_rdy) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
          cur = '{res: 16'h0, n: 0, hold: 0, acc: cyc};
        end else begin
          cur = q.pop_front();
          chk("result_data", bus.result_data, cur.res);
          chk("latency", cyc - cur.acc, cur.n);
          chk("iter_count", bus.iter_count, exp_it(cur.n));
        end
        hold_cnt = 0;
      end
      prev_rdy = bus.result_rdy;
      if (took) begin
        chk("idle_after_take", bus.state, 0);
        took = 0;
      end
      if (bus.result_taken) begin
        bus.result_taken = 1'b0;
      end else if (bus.result_rdy) begin
        if (hold_cnt < cur.hold) begin
          hold_cnt++;
          chk("hold_data", bus.result_data, cur.res);
          chk("hold_ready_low", bus.input_ready, 0);
        end else begin
          bus.result_taken = 1'b1;
          took = 1;
        end
      end
    end
  end

  exp_t cur4;
  bit   prev_rdy4 = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rdy4         = 0;
      bus4.result_taken = 1'b0;
    end else begin
      bus4.result_taken = 1'b0;
      if (bus4.result_rdy && !prev_rdy4) begin
        if (q4.size() == 0) begin
          chk("w4_unexpected_result", 1, 0);
        end else begin
          cur4 = q4.pop_front();
          chk("w4_result_data", bus4.result_data, cur4.res);
          chk("w4_latency", cyc - cur4.acc, cur4.n);
          chk("w4_iter_count", bus4.iter_count, exp_it(cur4.n));
        end
        bus4.result_taken = 1'b1;
      end
      prev_rdy4 = bus4.result_rdy;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok4;
    reset_n              = 1'b0;
    bus.operand_A        = '0;
    bus.operand_B        = '0;
    bus.input_available  = 1'b0;
    bus4.operand_A       = '0;
    bus4.operand_B       = '0;
    bus4.input_available = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", bus.state, 0);
    chk("reset_input_ready", bus.input_ready, 1);
    chk("reset_result_rdy", bus.result_rdy, 0);
    chk("reset_result_data", bus.result_data, 0);
    chk("reset_iter_count", bus.iter_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Second pair is presented while the first is still in CALC.
    send(16'd270, 16'd192, 16, 2, 16'd6);
    send(16'd12,  16'd0,   1,  0, 16'd12);
    send(16'd0,   16'd5,   2,  0, 16'd5);
    send(16'd0,   16'd0,   1,  0, 16'd0);
    send(16'd7,   16'd7,   3,  0, 16'd7);
    send(16'd100, 16'd75,  7,  1, 16'd25);
    send(16'd270, 16'd192, 16, 20, 16'd6);
    send(16'd48,  16'd18,  9,  0, 16'd6);
    drain();

    send(16'd270, 16'd192, 16, 0, 16'd6);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_state", bus.state, 0);
    chk("midreset_input_ready", bus.input_ready, 1);
    chk("midreset_result_rdy", bus.result_rdy, 0);
    chk("midreset_result_data", bus.result_data, 0);
    chk("midreset_iter_count", bus.iter_count, 0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(16'd270, 16'd192, 16, 0, 16'd6);
    drain();

    bus4.operand_A       = 4'd15;
    bus4.operand_B       = 4'd1;
    bus4.input_available = 1'b1;
    ok4 = 0;
    for (int i = 0; i < 50 && !ok4; i++) begin
      if (bus4.input_ready) ok4 = 1;
      @(negedge clk);
    end
    bus4.input_available = 1'b0;
    chk("w4_accept_timeout", ok4, 1);
    if (ok4) q4.push_back('{res: 16'd1, n: 17, hold: 0, acc: cyc});
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
